avalon_slave_mem: RTL

- Avalon-MM slave (responder) memory model for the Avalon VIP library; the responding end for the avalon_master/avalon_driver initiator.
- Word-addressed register array with a fixed, parameterised number of waitrequest cycles per transfer and registered read data.
- Used in benches as the target of master sequences; synthesizable so it can also serve as a simple on-chip RAM slave.

---
 rtl/avalon_slave_mem_if.sv | 32 +++
 rtl/avalon_slave_mem.sv | 103 ++++++++++
 2 files changed

// File: rtl/avalon_slave_mem_if.sv
// rtl/avalon_slave_mem_if.sv - Avalon-MM bus bundle between initiator and avalon_slave_mem (AVALON_SLAVE_BYTEENABLE_EN adds byteenable)
interface avalon_slave_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;
    logic              err;
`ifdef AVALON_SLAVE_BYTEENABLE_EN
    logic [DATA_W/8-1:0] byteenable;
`endif

    modport master (
`ifdef AVALON_SLAVE_BYTEENABLE_EN
        output byteenable,
`endif
        output address, read, write, writedata,
        input  readdata, waitrequest, err
    );

    modport slave (
`ifdef AVALON_SLAVE_BYTEENABLE_EN
        input  byteenable,
`endif
        input  address, read, write, writedata,
        output readdata, waitrequest, err
    );
endinterface

// File: rtl/avalon_slave_mem.sv
// rtl/avalon_slave_mem.sv - Avalon-MM slave RAM with fixed waitrequest cycles and registered read data
// Define AVALON_SLAVE_BYTEENABLE_EN to enable per-byte write masking.
module avalon_slave_mem #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    avalon_slave_mem_if.slave   bus
);
    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(WAIT_CYCLES);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              err_q, err_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic             req;
    logic             stall;
    logic             accept;
    logic             in_range;
    logic             mem_we;
    logic [IDX_W-1:0] idx;

    assign req      = bus.read | bus.write;
    // The IDLE cycle sees cnt_q==0, so it always counts as the first wait cycle.
    assign stall    = req && (cnt_q != CNT_MAX);
    assign accept   = req && !stall;
    assign in_range = {1'b0, bus.address} < DEPTH_L;
    assign idx      = bus.address[IDX_W-1:0];
    assign mem_we   = accept && bus.write && in_range;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        readdata_d = readdata_q;
        err_d      = err_q;

        if (accept) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (bus.read && bus.write) begin
                err_d = 1'b1;
            end
        end else if (req) begin
            state_d = BUSY;
            cnt_d   = cnt_q + CNT_W'(1);
        end else begin
            // Request withdrawn mid-transfer: abort and flag it.
            state_d = IDLE;
            cnt_d   = '0;
            if (state_q == BUSY) begin
                err_d = 1'b1;
            end
        end

        if (bus.read && stall) begin
            readdata_d = in_range ? mem[idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            readdata_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            readdata_q <= readdata_d;
            err_q      <= err_d;
        end
    end

    // Storage has no reset; accept can only fire with rst_n high since cnt_q is held at 0.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef AVALON_SLAVE_BYTEENABLE_EN
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (bus.byteenable[b]) begin
                    mem[idx][8*b +: 8] <= bus.writedata[8*b +: 8];
                end
            end
`else
            mem[idx] <= bus.writedata;
`endif
        end
    end

    assign bus.readdata    = readdata_q;
    assign bus.waitrequest = !rst_n || stall;
    assign bus.err         = err_q;
endmodule
